palette_lut_anim: RTL and testbench

//  Programmable multi-bank sprite colour palette; successor to fixed per-sprite palette ROMs.

---
 rtl/palette_lut_anim.sv | 144 ++++++++++++++
 tb/tb_palette_lut_anim.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_anim.sv
// Multi-bank writable sprite palette with 2-cycle lookup, transparent-key flag and per-frame
// index rotation; define PALETTE_CYCLE_EN to build the rotation logic.
module palette_lut_anim #(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned NUM_BANK  = 4,
    parameter int unsigned TRANS_IDX = 0,
    parameter int unsigned CYC_LO    = 7,
    parameter int unsigned CYC_HI    = 10,
    parameter int unsigned CYC_DIV   = 4,
    localparam int unsigned BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [BANK_W-1:0] wr_bank_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [23:0]       wr_rgb_i,
    input  logic              rd_valid_i,
    input  logic [BANK_W-1:0] rd_bank_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic              frame_tick_i,
    input  logic              cyc_enable_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              transparent_o,
    output logic              rd_valid_o
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [23:0]       mem_q [NUM_BANK][DEPTH];
    logic [IDX_W-1:0]  eff_idx_d;
    logic [BANK_W-1:0] bank_d;

    logic              s1_valid_q;
    logic [BANK_W-1:0] s1_bank_q;
    logic [IDX_W-1:0]  s1_idx_q;
    logic              s1_trans_q;

    logic [23:0]       rgb_q;
    logic              trans_q;
    logic              valid_q;

`ifdef PALETTE_CYCLE_EN
    localparam int unsigned CYC_LEN = CYC_HI - CYC_LO + 1;
    localparam int unsigned CNT_W   = (CYC_DIV > 1) ? $clog2(CYC_DIV) : 1;
    localparam logic [IDX_W:0] CycLoW  = (IDX_W + 1)'(CYC_LO);
    localparam logic [IDX_W:0] CycHiW  = (IDX_W + 1)'(CYC_HI);
    localparam logic [IDX_W:0] CycLenW = (IDX_W + 1)'(CYC_LEN);

    logic [IDX_W-1:0] cyc_off_q, cyc_off_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [IDX_W:0]   raw_w, sum_w;
    logic             eff_unused_msb;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        cyc_off_d   = cyc_off_q;
        if (frame_tick_i && cyc_enable_i) begin
            if (frame_cnt_q == CNT_W'(CYC_DIV - 1)) begin
                frame_cnt_d = '0;
                cyc_off_d   = (cyc_off_q == IDX_W'(CYC_LEN - 1)) ? '0 : cyc_off_q + 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            cyc_off_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            cyc_off_q   <= cyc_off_d;
        end
    end

    // Both operands of the sum are below CYC_LEN, so one conditional subtract is the modulo.
    always_comb begin
        raw_w = {1'b0, rd_idx_i};
        sum_w = raw_w - CycLoW + {1'b0, cyc_off_q};
        if (sum_w >= CycLenW) begin
            sum_w = sum_w - CycLenW;
        end
        if (raw_w >= CycLoW && raw_w <= CycHiW) begin
            {eff_unused_msb, eff_idx_d} = sum_w + CycLoW;
        end else begin
            {eff_unused_msb, eff_idx_d} = raw_w;
        end
    end
`else
    logic unused_cyc_inputs;
    assign unused_cyc_inputs = frame_tick_i ^ cyc_enable_i;
    assign eff_idx_d = rd_idx_i;
`endif

    assign bank_d = (32'(rd_bank_i) < NUM_BANK) ? rd_bank_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_en_i && (32'(wr_bank_i) < NUM_BANK)) begin
            mem_q[wr_bank_i][wr_idx_i] <= wr_rgb_i;
        end
    end

    // A write landing on the S2 edge is not visible here: the read sees the pre-edge entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= '0;
            s1_idx_q   <= '0;
            s1_trans_q <= 1'b0;
            rgb_q      <= '0;
            trans_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            s1_valid_q <= rd_valid_i;
            if (rd_valid_i) begin
                s1_bank_q  <= bank_d;
                s1_idx_q   <= eff_idx_d;
                s1_trans_q <= (rd_idx_i == IDX_W'(TRANS_IDX));
            end
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rgb_q   <= mem_q[s1_bank_q][s1_idx_q];
                trans_q <= s1_trans_q;
            end
        end
    end

    assign red_o         = rgb_q[23:16];
    assign green_o       = rgb_q[15:8];
    assign blue_o        = rgb_q[7:0];
    assign transparent_o = trans_q;
    assign rd_valid_o    = valid_q;

endmodule

// File: tb/tb_palette_lut_anim.sv
// Directed bench for palette_lut_anim; expectations follow the PALETTE_CYCLE_EN setting.
module tb_palette_lut_anim;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_idx;
    logic [23:0] wr_rgb;
    logic        rd_valid;
    logic [1:0]  rd_bank;
    logic [3:0]  rd_idx;
    logic        frame_tick;
    logic        cyc_enable;
    logic [7:0]  red, green, blue;
    logic        transparent;
    logic        rd_valid_out;

    int n_checks = 0;
    int n_errors = 0;

    palette_lut_anim dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_en_i      (wr_en),
        .wr_bank_i    (wr_bank),
        .wr_idx_i     (wr_idx),
        .wr_rgb_i     (wr_rgb),
        .rd_valid_i   (rd_valid),
        .rd_bank_i    (rd_bank),
        .rd_idx_i     (rd_idx),
        .frame_tick_i (frame_tick),
        .cyc_enable_i (cyc_enable),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue),
        .transparent_o(transparent),
        .rd_valid_o   (rd_valid_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [23:0] rgb);
        wr_en = 1'b1; wr_bank = b; wr_idx = i; wr_rgb = rgb;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] b, input logic [3:0] i);
        rd_valid = 1'b1; rd_bank = b; rd_idx = i;
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rgb_out();
        return {8'h00, red, green, blue};
    endfunction

    initial begin
        logic [23:0] exp_i7, exp_i10;
        rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_idx = '0; wr_rgb = '0;
        rd_valid = 1'b0; rd_bank = '0; rd_idx = '0; frame_tick = 1'b0; cyc_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_valid", 32'(rd_valid_out), 32'd0);
        check_eq("reset_rgb", rgb_out(), 32'h0);
        check_eq("reset_trans", 32'(transparent), 32'd0);

        // Latency: not valid after one edge, valid after two.
        rd_valid = 1'b1; rd_bank = 2'd0; rd_idx = 4'd5;
        @(negedge clk);
        rd_valid = 1'b0;
        check_eq("lat1_valid", 32'(rd_valid_out), 32'd0);
        @(negedge clk);
        check_eq("lat2_valid", 32'(rd_valid_out), 32'd1);
        check_eq("b0i5_rgb", rgb_out(), 32'h0);
        check_eq("b0i5_trans", 32'(transparent), 32'd0);

        // Back-to-back lookups.
        wr(2'd1, 4'd3, 24'hFBD705);
        rd_valid = 1'b1; rd_bank = 2'd1; rd_idx = 4'd3;
        @(negedge clk);
        @(negedge clk);
        check_eq("b2b0_valid", 32'(rd_valid_out), 32'd1);
        check_eq("b2b0_rgb", rgb_out(), 32'hFBD705);
        @(negedge clk);
        rd_valid = 1'b0;
        check_eq("b2b1_valid", 32'(rd_valid_out), 32'd1);
        check_eq("b2b1_rgb", rgb_out(), 32'hFBD705);
        @(negedge clk);
        check_eq("b2b2_valid", 32'(rd_valid_out), 32'd1);
        check_eq("b2b2_rgb", rgb_out(), 32'hFBD705);
        @(negedge clk);
        check_eq("b2b_end_valid", 32'(rd_valid_out), 32'd0);
        check_eq("hold_rgb", rgb_out(), 32'hFBD705);

        // Transparent key uses the raw index.
        lookup(2'd0, 4'd0);
        check_eq("i0_trans", 32'(transparent), 32'd1);
        lookup(2'd0, 4'd1);
        check_eq("i1_trans", 32'(transparent), 32'd0);

        // Rotation.
        wr(2'd2, 4'd6, 24'h666666);
        wr(2'd2, 4'd7, 24'h111111);
        wr(2'd2, 4'd8, 24'h222222);
        wr(2'd2, 4'd9, 24'h333333);
        wr(2'd2, 4'd10, 24'h444444);
        lookup(2'd2, 4'd7);
        check_eq("rot0_i7", rgb_out(), 32'h111111);
        cyc_enable = 1'b1;
        ticks(4);
`ifdef PALETTE_CYCLE_EN
        exp_i7 = 24'h222222; exp_i10 = 24'h111111;
`else
        exp_i7 = 24'h111111; exp_i10 = 24'h444444;
`endif
        lookup(2'd2, 4'd7);
        check_eq("rot1_i7", rgb_out(), 32'(exp_i7));
        lookup(2'd2, 4'd10);
        check_eq("rot1_i10", rgb_out(), 32'(exp_i10));
        lookup(2'd2, 4'd6);
        check_eq("rot1_i6", rgb_out(), 32'h666666);
        ticks(12);
        lookup(2'd2, 4'd7);
        check_eq("wrap_i7", rgb_out(), 32'h111111);
        lookup(2'd2, 4'd10);
        check_eq("wrap_i10", rgb_out(), 32'h444444);
        lookup(2'd2, 4'd6);
        check_eq("wrap_i6", rgb_out(), 32'h666666);
        cyc_enable = 1'b0;
        ticks(4);
        lookup(2'd2, 4'd7);
        check_eq("frozen_i7", rgb_out(), 32'h111111);

        // Write on the S2 edge of a lookup to the same entry.
        wr(2'd3, 4'd2, 24'h123456);
        rd_valid = 1'b1; rd_bank = 2'd3; rd_idx = 4'd2;
        @(negedge clk);
        rd_valid = 1'b0;
        wr(2'd3, 4'd2, 24'hFF0000);
        check_eq("coll_old", rgb_out(), 32'h123456);
        lookup(2'd3, 4'd2);
        check_eq("coll_new", rgb_out(), 32'hFF0000);

        // Reset with a lookup in flight and a nonzero rotation offset.
        cyc_enable = 1'b1;
        ticks(4);
        cyc_enable = 1'b0;
        rd_valid = 1'b1; rd_bank = 2'd3; rd_idx = 4'd2;
        @(negedge clk);
        rst = 1'b1;
        rd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_fl_valid", 32'(rd_valid_out), 32'd0);
        check_eq("rst_fl_rgb", rgb_out(), 32'h0);
        @(negedge clk);
        check_eq("rst_fl_valid2", 32'(rd_valid_out), 32'd0);
        wr(2'd2, 4'd7, 24'h111111);
        wr(2'd2, 4'd8, 24'h222222);
        lookup(2'd2, 4'd7);
        check_eq("rst_cycoff", rgb_out(), 32'h111111);
        lookup(2'd3, 4'd2);
        check_eq("rst_mem_clr", rgb_out(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
